// File: rtl/mask_sequencer_pkg.sv
// Shared types and defaults for the mask sequencer: sequencer states, vector
// geometry defaults and a width helper for group indices.
package mask_sequencer_pkg;

    localparam int NUM_ELEMENTS   = 32;
    localparam int MASK_SEQ_LANES = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } seq_state_e;

    // A single-group configuration still needs a one-bit index signal.
    function automatic int width_min1(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mask_sequencer_if.sv
// Mask-unit to lanes bundle: instruction mask handshake in, per-group lane beats out.
interface mask_sequencer_if #(
    parameter int NUM_ELEMENTS = mask_sequencer_pkg::NUM_ELEMENTS,
    parameter int NUM_LANES    = mask_sequencer_pkg::MASK_SEQ_LANES
);
    localparam int VL_W    = $clog2(NUM_ELEMENTS) + 1;
    localparam int GROUP_W = mask_sequencer_pkg::width_min1(NUM_ELEMENTS / NUM_LANES);

    logic                    in_valid;
    logic                    in_ready;
    logic [NUM_ELEMENTS-1:0] in_mask;
    logic [VL_W-1:0]         in_vl;
    logic                    out_valid;
    logic                    out_ready;
    logic [NUM_LANES-1:0]    out_lane_en;
    logic [GROUP_W-1:0]      out_group;
    logic                    out_last;
    logic                    done;

    // master: mask unit plus lanes side; slave: the sequencer itself
    modport master (
        output in_valid, in_mask, in_vl, out_ready,
        input  in_ready, out_valid, out_lane_en, out_group, out_last, done
    );

    modport slave (
        input  in_valid, in_mask, in_vl, out_ready,
        output in_ready, out_valid, out_lane_en, out_group, out_last, done
    );

endinterface

// File: rtl/mask_sequencer_group_scan.sv
// Combinational view of the latched mask at group g: its lane bits and whether
// any higher group still has work.
module mask_sequencer_group_scan
    import mask_sequencer_pkg::*;
#(
    parameter int NUM_ELEMENTS = 32,
    parameter int NUM_LANES    = 4,
    parameter int GROUP_W      = width_min1(NUM_ELEMENTS / NUM_LANES)
) (
    input  logic [NUM_ELEMENTS-1:0] eff_mask,
    input  logic [GROUP_W-1:0]      g,
    output logic [NUM_LANES-1:0]    cur,
    output logic                    rem
);
    localparam int NUM_GROUPS = NUM_ELEMENTS / NUM_LANES;

    logic [NUM_LANES-1:0]  groups [NUM_GROUPS];
    logic [NUM_GROUPS-1:0] above;

    for (genvar gi = 0; gi < NUM_GROUPS; gi++) begin : g_scan
        assign groups[gi] = eff_mask[gi*NUM_LANES +: NUM_LANES];
        if (gi == NUM_GROUPS - 1) begin : g_top
            assign above[gi] = 1'b0;
        end else begin : g_mid
            assign above[gi] = |eff_mask[NUM_ELEMENTS-1:(gi+1)*NUM_LANES];
        end
    end

    assign cur = groups[g];
    assign rem = above[g];

endmodule

// File: rtl/mask_sequencer.sv
// Walks a latched element mask one lane group per beat, skipping empty groups
// at one cycle each, and pulses done the cycle after an instruction finishes.
module mask_sequencer
    import mask_sequencer_pkg::*;
#(
    parameter int NUM_ELEMENTS = mask_sequencer_pkg::NUM_ELEMENTS,
    parameter int NUM_LANES    = mask_sequencer_pkg::MASK_SEQ_LANES
) (
    input  logic             clk,
    input  logic             rst_n,
    mask_sequencer_if.slave  bus
);
    localparam int NUM_GROUPS = NUM_ELEMENTS / NUM_LANES;
    localparam int VL_W       = $clog2(NUM_ELEMENTS) + 1;
    localparam int GROUP_W    = width_min1(NUM_GROUPS);
    localparam logic [GROUP_W-1:0] G_LAST = GROUP_W'(NUM_GROUPS - 1);

    seq_state_e              state_reg, state_next;
    logic [NUM_ELEMENTS-1:0] eff_mask_reg, eff_mask_next, accept_mask;
    logic [GROUP_W-1:0]      g_reg, g_next;
    logic                    done_reg, done_next;
    logic [NUM_LANES-1:0]    cur;
    logic                    rem;

    // Elements at or beyond vl are dropped; vl above NUM_ELEMENTS saturates naturally.
    for (genvar gi = 0; gi < NUM_ELEMENTS; gi++) begin : g_vl
        assign accept_mask[gi] = bus.in_mask[gi] && (VL_W'(gi) < bus.in_vl);
    end

    mask_sequencer_group_scan #(
        .NUM_ELEMENTS (NUM_ELEMENTS),
        .NUM_LANES    (NUM_LANES),
        .GROUP_W      (GROUP_W)
    ) u_scan (
        .eff_mask (eff_mask_reg),
        .g        (g_reg),
        .cur      (cur),
        .rem      (rem)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            eff_mask_reg <= '0;
            g_reg        <= '0;
            done_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            eff_mask_reg <= eff_mask_next;
            g_reg        <= g_next;
            done_reg     <= done_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        eff_mask_next   = eff_mask_reg;
        g_next          = g_reg;
        done_next       = 1'b0;
        bus.in_ready    = (state_reg == IDLE);
        bus.out_valid   = 1'b0;
        bus.out_lane_en = '0;
        bus.out_last    = 1'b0;
        bus.out_group   = g_reg;

        case (state_reg)
            IDLE: begin
                if (bus.in_valid) begin
                    if (accept_mask == '0) begin
                        done_next = 1'b1;
                    end else begin
                        eff_mask_next = accept_mask;
                        g_next        = '0;
                        state_next    = ISSUE;
                    end
                end
            end
            ISSUE: begin
                if (cur == '0) begin
                    if (g_reg != G_LAST) g_next = g_reg + 1'b1;
                end else begin
                    bus.out_valid   = 1'b1;
                    bus.out_lane_en = cur;
                    bus.out_last    = !rem;
                    if (bus.out_ready) begin
                        if (rem) begin
                            g_next = g_reg + 1'b1;
                        end else begin
                            state_next    = IDLE;
                            g_next        = '0;
                            eff_mask_next = '0;
                            done_next     = 1'b1;
                        end
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign bus.done = done_reg;

endmodule

// File: tb/tb_mask_sequencer.sv
// Directed bench for mask_sequencer: full mask, sparse mask, short vl, vl=0,
// lane back-pressure and reset in the middle of an instruction.
module tb_mask_sequencer;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    mask_sequencer_if #(.NUM_ELEMENTS(32), .NUM_LANES(4)) bus ();

    mask_sequencer #(.NUM_ELEMENTS(32), .NUM_LANES(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_beat(input string tag, input int grp, input logic [3:0] en, input logic last);
        chk({tag, ".valid"}, 64'(bus.out_valid), 64'd1);
        chk({tag, ".group"}, 64'(bus.out_group), 64'(grp));
        chk({tag, ".lane_en"}, 64'(bus.out_lane_en), 64'(en));
        chk({tag, ".last"}, 64'(bus.out_last), 64'(last));
        chk({tag, ".done"}, 64'(bus.done), 64'd0);
        $display("%s: beat group=%0d lane_en=%h last=%b", tag, bus.out_group, bus.out_lane_en, bus.out_last);
    endtask

    task automatic expect_skip(input string tag);
        chk({tag, ".valid"}, 64'(bus.out_valid), 64'd0);
        chk({tag, ".done"}, 64'(bus.done), 64'd0);
        $display("%s: skip cycle group=%0d", tag, bus.out_group);
    endtask

    task automatic expect_done(input string tag);
        chk({tag, ".done"}, 64'(bus.done), 64'd1);
        chk({tag, ".valid"}, 64'(bus.out_valid), 64'd0);
        chk({tag, ".in_ready"}, 64'(bus.in_ready), 64'd1);
        tick();
        chk({tag, ".done_clr"}, 64'(bus.done), 64'd0);
        $display("%s: instruction done", tag);
    endtask

    task automatic issue(input string tag, input logic [31:0] mask, input int vl);
        bus.in_mask  = mask;
        bus.in_vl    = 6'(vl);
        bus.in_valid = 1'b1;
        chk({tag, ".in_ready"}, 64'(bus.in_ready), 64'd1);
        tick();
        bus.in_valid = 1'b0;
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_mask   = '0;
        bus.in_vl     = '0;
        bus.out_ready = 1'b1;

        // Reset state
        #12;
        chk("rst.in_ready", 64'(bus.in_ready), 64'd1);
        chk("rst.valid", 64'(bus.out_valid), 64'd0);
        chk("rst.lane_en", 64'(bus.out_lane_en), 64'd0);
        chk("rst.group", 64'(bus.out_group), 64'd0);
        chk("rst.last", 64'(bus.out_last), 64'd0);
        chk("rst.done", 64'(bus.done), 64'd0);
        rst_n = 1'b1;
        tick();

        // Full mask, vl=32: eight back-to-back beats
        issue("t1", 32'hFFFF_FFFF, 32);
        for (int k = 0; k < 8; k++) begin
            expect_beat($sformatf("t1.g%0d", k), k, 4'hF, k == 7);
            tick();
        end
        expect_done("t1");

        // Sparse mask: groups 1 and 2 skipped; input changes mid-issue ignored
        issue("t2", 32'h0000_F00F, 32);
        bus.in_mask = 32'h0;
        bus.in_vl   = 6'd0;
        expect_beat("t2.g0", 0, 4'hF, 1'b0);
        tick();
        expect_skip("t2.s1");
        tick();
        expect_skip("t2.s2");
        tick();
        expect_beat("t2.g3", 3, 4'hF, 1'b1);
        tick();
        expect_done("t2");

        // Short vector length truncates group 1
        issue("t3", 32'hFFFF_FFFF, 6);
        expect_beat("t3.g0", 0, 4'hF, 1'b0);
        tick();
        expect_beat("t3.g1", 1, 4'h3, 1'b1);
        tick();
        expect_done("t3");

        // vl=0: no beats, done immediately after acceptance
        issue("t4", 32'hFFFF_FFFF, 0);
        chk("t4.in_ready", 64'(bus.in_ready), 64'd1);
        expect_done("t4");

        // Lane back-pressure holds group 0 for three cycles
        bus.out_ready = 1'b0;
        issue("t5", 32'hFFFF_FFFF, 8);
        for (int k = 0; k < 3; k++) begin
            expect_beat($sformatf("t5.hold%0d", k), 0, 4'hF, 1'b0);
            tick();
        end
        bus.out_ready = 1'b1;
        expect_beat("t5.g0", 0, 4'hF, 1'b0);
        tick();
        expect_beat("t5.g1", 1, 4'hF, 1'b1);
        tick();
        expect_done("t5");

        // Reset during group 2 abandons the instruction
        issue("t6", 32'hFFFF_FFFF, 32);
        tick();
        tick();
        expect_beat("t6.g2", 2, 4'hF, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6.rst.valid", 64'(bus.out_valid), 64'd0);
        chk("t6.rst.lane_en", 64'(bus.out_lane_en), 64'd0);
        chk("t6.rst.group", 64'(bus.out_group), 64'd0);
        chk("t6.rst.last", 64'(bus.out_last), 64'd0);
        tick();
        tick();
        chk("t6.rst.done", 64'(bus.done), 64'd0);
        rst_n = 1'b1;
        tick();
        chk("t6.post.done", 64'(bus.done), 64'd0);
        chk("t6.post.in_ready", 64'(bus.in_ready), 64'd1);
        chk("t6.post.valid", 64'(bus.out_valid), 64'd0);
        $display("t6: reset mid-issue, instruction abandoned");

        issue("t7", 32'hFFFF_FFFF, 6);
        expect_beat("t7.g0", 0, 4'hF, 1'b0);
        tick();
        expect_beat("t7.g1", 1, 4'h3, 1'b1);
        tick();
        expect_done("t7");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
